// File: rtl/ext_intr_ctrl_pkg.sv
// Shared MSR layout, vector addresses and sequencer state encoding for the
// external-interrupt controller.
package ext_intr_ctrl_pkg;

    localparam int MSR_W_DEF  = 32;
    localparam int MSR_EE_BIT = 16;
    localparam int MSR_ME_BIT = 19;
    localparam int MSR_LE_BIT = 31;

    // Implemented MSR bits: EE, ME and LE in big-endian numbering
    localparam logic [31:0] MSR_MASK     = 32'h0000_9001;
    localparam logic [31:0] EXT_VEC_ADDR = 32'h0000_0500;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_SAVE   = 3'd2,
        ST_VECTOR = 3'd3,
        ST_RFI    = 3'd4
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ext_intr_ctrl_sync_ff.sv
// Parameterized flop chain that brings an asynchronous level into the clk
// domain; cleared by the synchronous reset.
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/ext_intr_ctrl.sv
// External-interrupt sequencer: drains the pipe, saves SRR0/SRR1, clears EE and
// vectors fetch; also executes rfi by restoring MSR from SRR1.
module ext_intr_ctrl
    import ext_intr_ctrl_pkg::*;
#(
    parameter int          MSR_WIDTH   = MSR_W_DEF,
    parameter logic [31:0] VEC_ADDR    = EXT_VEC_ADDR,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ext_irq,
    input  logic [0:MSR_WIDTH-1] msr_rd,
    input  logic                 msr_ee,
    input  logic [31:0]          npc,
    input  logic                 pipe_empty,
    input  logic                 rfi_req,
    input  logic [31:0]          srr0_rd,
    input  logic [0:MSR_WIDTH-1] srr1_rd,
    output logic                 stall_req,
    output logic                 msr_wr,
    output logic [0:MSR_WIDTH-1] msr_wd,
    output logic                 srr0_wr,
    output logic                 srr1_wr,
    output logic [31:0]          srr0_wd,
    output logic [0:MSR_WIDTH-1] srr1_wd,
    output logic                 pc_redirect,
    output logic [31:0]          redirect_pc,
    output logic                 int_ack
);

    localparam logic [0:MSR_WIDTH-1] L_MASK = MSR_WIDTH'(MSR_MASK);

    logic   w_irq_s;
    state_t r_state;
    state_t w_next;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_irq_sync (
        .clk (clk),
        .rst (rst),
        .i_d (ext_irq),
        .o_q (w_irq_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // rfi wins over a simultaneously pending interrupt
                if (rfi_req) begin
                    w_next = ST_RFI;
                end else if (w_irq_s && msr_ee) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!w_irq_s) begin
                    w_next = ST_IDLE;
                end else if (pipe_empty) begin
                    w_next = ST_SAVE;
                end
            end
            ST_SAVE:   w_next = ST_VECTOR;
            ST_VECTOR: w_next = ST_IDLE;
            ST_RFI:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_req   = 1'b0;
        msr_wr      = 1'b0;
        msr_wd      = '0;
        srr0_wr     = 1'b0;
        srr1_wr     = 1'b0;
        srr0_wd     = '0;
        srr1_wd     = '0;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        int_ack     = 1'b0;
        case (r_state)
            ST_DRAIN: begin
                stall_req = 1'b1;
            end
            ST_SAVE: begin
                stall_req = 1'b1;
                srr0_wr   = 1'b1;
                srr1_wr   = 1'b1;
                srr0_wd   = npc;
                srr1_wd   = msr_rd & L_MASK;
            end
            ST_VECTOR: begin
                stall_req          = 1'b1;
                msr_wr             = 1'b1;
                msr_wd             = msr_rd & L_MASK;
                msr_wd[MSR_EE_BIT] = 1'b0;
                pc_redirect        = 1'b1;
                redirect_pc        = VEC_ADDR;
                int_ack            = 1'b1;
            end
            ST_RFI: begin
                stall_req   = 1'b1;
                msr_wr      = 1'b1;
                msr_wd      = srr1_rd & L_MASK;
                pc_redirect = 1'b1;
                redirect_pc = word_align(srr0_rd);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ext_intr_ctrl.sv
// Directed bench for ext_intr_ctrl with a queue-based reference model and
// per-cycle output comparison.
module tb_ext_intr_ctrl;

    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_irq;
    logic [0:31] tb_msr = '0;
    logic        msr_ld;
    logic [31:0] msr_ld_val;
    logic [31:0] npc;
    logic        pipe_empty;
    logic        rfi_req;
    logic [31:0] srr0_rd;
    logic [0:31] srr1_rd;
    logic        stall_req;
    logic        msr_wr;
    logic [0:31] msr_wd;
    logic        srr0_wr;
    logic        srr1_wr;
    logic [31:0] srr0_wd;
    logic [0:31] srr1_wd;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        int_ack;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    ext_intr_ctrl #(
        .MSR_WIDTH   (32),
        .VEC_ADDR    (32'h0000_0500),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ext_irq     (ext_irq),
        .msr_rd      (tb_msr),
        .msr_ee      (tb_msr[16]),
        .npc         (npc),
        .pipe_empty  (pipe_empty),
        .rfi_req     (rfi_req),
        .srr0_rd     (srr0_rd),
        .srr1_rd     (srr1_rd),
        .stall_req   (stall_req),
        .msr_wr      (msr_wr),
        .msr_wd      (msr_wd),
        .srr0_wr     (srr0_wr),
        .srr1_wr     (srr1_wr),
        .srr0_wd     (srr0_wd),
        .srr1_wd     (srr1_wd),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .int_ack     (int_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The bench plays the MSR block: it loads directed values or takes the DUT's write.
    always @(posedge clk) begin
        if (msr_ld) tb_msr <= msr_ld_val;
        else if (msr_wr) tb_msr <= msr_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plan holds the remaining fixed-length actions
    // (1=save, 2=vector, 3=rfi); waiting means stalled for the pipe to empty.
    int plan[$];
    bit waiting  = 1'b0;
    bit model_ok = 1'b0;
    bit hist [SYNC_STAGES];

    always @(posedge clk) begin
        bit irq_seen;
        irq_seen = hist[SYNC_STAGES-1];
        if (rst) begin
            plan.delete();
            waiting  = 1'b0;
            model_ok = 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) hist[i] = 1'b0;
        end else begin
            if (plan.size() > 0) begin
                void'(plan.pop_front());
            end else if (waiting) begin
                if (!irq_seen) begin
                    waiting = 1'b0;
                end else if (pipe_empty) begin
                    waiting = 1'b0;
                    plan.push_back(1);
                    plan.push_back(2);
                end
            end else if (rfi_req) begin
                plan.push_back(3);
            end else if (irq_seen && tb_msr[16]) begin
                waiting = 1'b1;
            end
            for (int i = SYNC_STAGES - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = ext_irq;
        end
    end

    always @(negedge clk) begin
        int act;
        if (model_ok) begin
            act = (plan.size() > 0) ? plan[0] : (waiting ? 4 : 0);
            chk("stall_req", 32'(stall_req), 32'(act != 0));
            chk("srr0_wr", 32'(srr0_wr), 32'(act == 1));
            chk("srr1_wr", 32'(srr1_wr), 32'(act == 1));
            chk("srr0_wd", srr0_wd, (act == 1) ? npc : 32'h0);
            chk("srr1_wd", srr1_wd, (act == 1) ? (tb_msr & 32'h0000_9001) : 32'h0);
            chk("msr_wr", 32'(msr_wr), 32'(act == 2 || act == 3));
            chk("msr_wd", msr_wd, (act == 2) ? (tb_msr & 32'h0000_1001) :
                                  (act == 3) ? (srr1_rd & 32'h0000_9001) : 32'h0);
            chk("pc_redirect", 32'(pc_redirect), 32'(act == 2 || act == 3));
            chk("redirect_pc", redirect_pc, (act == 2) ? 32'h0000_0500 :
                                            (act == 3) ? (srr0_rd & 32'hFFFF_FFFC) : 32'h0);
            chk("int_ack", 32'(int_ack), 32'(act == 2));
        end
    end

    int          srr_cnt = 0;
    int          ack_cnt = 0;
    int          stall_cnt = 0;
    logic [31:0] cap_srr0 = '0;
    logic [31:0] cap_srr1 = '0;

    always @(negedge clk) begin
        if (srr0_wr) begin
            srr_cnt++;
            cap_srr0 = srr0_wd;
            cap_srr1 = srr1_wd;
        end
        if (int_ack) ack_cnt++;
        if (stall_req) stall_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_msr(input logic [31:0] v);
        msr_ld     = 1'b1;
        msr_ld_val = v;
        step();
        msr_ld     = 1'b0;
    endtask

    task automatic wait_stall(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall_req) return;
        end
        chk({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_redirect(input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pc_redirect) return;
        end
        chk({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        int t0, s0, a0, st0;
        rst = 1'b1; ext_irq = 1'b0; msr_ld = 1'b0; msr_ld_val = '0;
        npc = 32'h0000_1234; pipe_empty = 1'b1; rfi_req = 1'b0;
        srr0_rd = '0; srr1_rd = '0;
        repeat (3) step();
        chk("rst_stall", 32'(stall_req), 32'h0);
        chk("rst_redirect", 32'(pc_redirect), 32'h0);
        rst = 1'b0;

        // Reset in the middle of a drain
        set_msr(32'h0000_9001);
        pipe_empty = 1'b0;
        ext_irq    = 1'b1;
        wait_stall("drain_rst");
        step(); step();
        rst = 1'b1; ext_irq = 1'b0;
        step();
        rst = 1'b0;
        chk("after_rst_stall", 32'(stall_req), 32'h0);
        repeat (6) step();
        chk("rst_no_srr_wr", 32'(srr_cnt), 32'h0);
        chk("rst_idle_stall", 32'(stall_req), 32'h0);

        // Basic interrupt with the pipe already empty
        pipe_empty = 1'b1;
        npc        = 32'h0000_1234;
        a0 = ack_cnt;
        ext_irq = 1'b1;
        t0 = cyc;
        wait_redirect("irq");
        chk("irq_latency", 32'(cyc - t0), 32'(SYNC_STAGES + 3));
        chk("irq_redirect_pc", redirect_pc, 32'h0000_0500);
        chk("irq_msr_wd", msr_wd, 32'h0000_1001);
        chk("irq_ack", 32'(int_ack), 32'h1);
        step();
        ext_irq = 1'b0;
        chk("irq_srr0", cap_srr0, 32'h0000_1234);
        chk("irq_srr1", cap_srr1, 32'h0000_9001);
        repeat (4) step();
        chk("irq_ack_once", 32'(ack_cnt - a0), 32'h1);
        chk("irq_msr_after", tb_msr, 32'h0000_1001);

        // Request held while EE is clear
        s0 = srr_cnt; st0 = stall_cnt; a0 = ack_cnt;
        ext_irq = 1'b1;
        repeat (20) step();
        chk("ee0_no_stall", 32'(stall_cnt - st0), 32'h0);
        chk("ee0_no_save", 32'(srr_cnt - s0), 32'h0);
        chk("ee0_no_ack", 32'(ack_cnt - a0), 32'h0);

        // Setting EE lets the held request in; pipe stays busy for 5 cycles
        pipe_empty = 1'b0;
        npc = 32'h0000_4440;
        set_msr(32'h0000_9001);
        wait_stall("drain");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_stall", 32'(stall_req), 32'h1);
            chk("drain_no_save", 32'(srr0_wr), 32'h0);
        end
        step();
        pipe_empty = 1'b1;
        wait_redirect("drain");
        step();
        ext_irq = 1'b0;
        chk("drain_saved_once", 32'(srr_cnt - s0), 32'h1);
        chk("drain_srr0", cap_srr0, 32'h0000_4440);
        repeat (4) step();

        // Spurious request dropped during drain
        s0 = srr_cnt; a0 = ack_cnt;
        pipe_empty = 1'b0;
        set_msr(32'h0000_9001);
        ext_irq = 1'b1;
        wait_stall("spur");
        step();
        ext_irq = 1'b0;
        repeat (6) step();
        chk("spur_no_save", 32'(srr_cnt - s0), 32'h0);
        chk("spur_no_ack", 32'(ack_cnt - a0), 32'h0);
        chk("spur_idle", 32'(stall_req), 32'h0);
        pipe_empty = 1'b1;

        // rfi with unaligned SRR0 and all-ones SRR1
        srr0_rd = 32'h0000_2007;
        srr1_rd = 32'hFFFF_FFFF;
        rfi_req = 1'b1;
        step();
        rfi_req = 1'b0;
        wait_redirect("rfi");
        chk("rfi_msr_wd", msr_wd, 32'h0000_9001);
        chk("rfi_redirect_pc", redirect_pc, 32'h0000_2004);
        chk("rfi_no_ack", 32'(int_ack), 32'h0);
        repeat (3) step();

        // rfi and interrupt in the same idle cycle: rfi first, then drain
        srr0_rd = 32'h0000_3000;
        srr1_rd = 32'h0000_8000;
        ext_irq = 1'b1;
        step(); step();
        rfi_req = 1'b1;
        step();
        rfi_req = 1'b0;
        @(negedge clk);
        chk("prio_rfi_redirect", 32'(pc_redirect), 32'h1);
        chk("prio_rfi_pc", redirect_pc, 32'h0000_3000);
        chk("prio_rfi_msr", msr_wd, 32'h0000_8000);
        @(negedge clk);
        chk("prio_idle_gap", 32'(stall_req), 32'h0);
        @(negedge clk);
        chk("prio_drain", 32'(stall_req), 32'h1);
        wait_redirect("prio_irq");
        chk("prio_irq_pc", redirect_pc, 32'h0000_0500);
        chk("prio_irq_msr", msr_wd, 32'h0000_0000);
        step();
        ext_irq = 1'b0;
        chk("prio_srr1", cap_srr1, 32'h0000_8000);
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ext_intr_ctrl.md
# ext_intr_ctrl

External-interrupt sequencer that drives the MSR write port and the SRR0/SRR1 save registers. It watches the external interrupt line against MSR.EE, drains the pipeline, saves the return context, clears EE and redirects fetch to the external-interrupt vector. It also executes `rfi`, restoring MSR from SRR1 and redirecting fetch to SRR0. It sits between the core's control unit and the MSR block, and is the only writer of MSR besides `mtmsr`; `mtmsr` arbitration is outside this block.

## Interface
- `MSR_WIDTH`, 32, width of MSR/SRR1 (big-endian bit numbering [0:MSR_WIDTH-1])
- `VEC_ADDR`, 32'h0000_0500, external-interrupt vector address
- `SYNC_STAGES`, 2, flops in the `ext_irq` synchronizer (≥2)
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `ext_irq`  in  1  asynchronous level-sensitive interrupt request; held by the device until `int_ack`
- `msr_rd`  in  [0:MSR_WIDTH-1]  current MSR value
- `msr_ee`  in  1  current MSR.EE (bit 16)
- `npc`  in  32  address of the next unexecuted instruction
- `pipe_empty`  in  1  all in-flight instructions retired
- `rfi_req`  in  1  one-cycle pulse from decode: execute `rfi`
- `srr0_rd`  in  32  current SRR0
- `srr1_rd`  in  [0:MSR_WIDTH-1]  current SRR1
- `stall_req`  out  1  freeze fetch/decode
- `msr_wr`  out  1  MSR write strobe
- `msr_wd`  out  [0:MSR_WIDTH-1]  MSR write data
- `srr0_wr`, `srr1_wr`  out  1  save strobes
- `srr0_wd`  out  32; `srr1_wd`  out  [0:MSR_WIDTH-1]  save data
- `pc_redirect`  out  1  fetch redirect strobe
- `redirect_pc`  out  32  redirect target
- `int_ack`  out  1  one-cycle acknowledge to the interrupt source

## Operation
- `ext_irq` passes through a `SYNC_STAGES` flop chain to give `irq_s`.
- MSR implemented-bit mask `MSR_MASK` = 32'h0000_9001 covers EE (bit 16), ME (bit 19) and LE (bit 31).
- FSM states: IDLE, DRAIN, SAVE, VECTOR, RFI.
- **IDLE:** all strobes are 0 and `stall_req`=0.
  - If `rfi_req`=1, go to RFI. `rfi_req` has priority over the interrupt.
  - Otherwise, if `irq_s` & `msr_ee`, go to DRAIN.
- **DRAIN:** `stall_req`=1.
  - If `irq_s` falls, treat it as spurious: return to IDLE with no side effects.
  - Otherwise, if `pipe_empty`=1, go to SAVE.
- **SAVE (1 cycle):** `stall_req`=1, `srr0_wr`=`srr1_wr`=1, `srr0_wd`=`npc`, `srr1_wd`=`msr_rd` & `MSR_MASK`. Go to VECTOR.
- **VECTOR (1 cycle):** `stall_req`=1 and the following are asserted together; then go to IDLE.
  - `msr_wr`=1, `msr_wd`=`msr_rd` & `MSR_MASK` with bit 16 cleared.
  - `pc_redirect`=1, `redirect_pc`=`VEC_ADDR`.
  - `int_ack`=1.
- **RFI (1 cycle):** `stall_req`=1 and the following are asserted together; then go to IDLE.
  - `msr_wr`=1, `msr_wd`=`srr1_rd` & `MSR_MASK`.
  - `pc_redirect`=1, `redirect_pc`={`srr0_rd`[31:2],2'b00}.
- `rfi_req` outside IDLE is ignored; decode is stalled there.
- Data outputs are 0 whenever their strobe is 0.

## Timing
- Reset: state goes to IDLE, synchronizer flops clear, and every output is 0 on the cycle after `rst` is sampled high. Reset asserted mid-sequence (e.g. in SAVE) aborts with no further strobes.
- All outputs are registered-state decodes (Moore); no input-to-output combinational path except data muxing from `npc`/`msr_rd`/`srr*_rd`.
- Interrupt latency with `pipe_empty` already high:
  - `ext_irq` rises → `irq_s` high after `SYNC_STAGES` edges.
  - DRAIN +1 cycle, SAVE +1, VECTOR +1.
  - Redirect occurs `SYNC_STAGES`+3 cycles after `ext_irq`.
- MSR updates on the edge ending VECTOR/RFI, so `msr_ee` seen in IDLE is already the new value. A pending `irq_s` after an `rfi` restoring EE=1 re-enters DRAIN on the first IDLE cycle.
- `irq_s` with `msr_ee`=0: no action; the request is held until EE is set.

## Structure
- Shared package/`arch_def.v`: `MSR_WIDTH`, MSR bit indices (EE=16, ME=19, LE=31), `MSR_MASK`, vector addresses, FSM state encodings.
- Sub-module `sync_ff` (parameterized flop chain) for `ext_irq`; reusable for other async inputs.

## Test plan
- Reset mid-DRAIN, then release → all outputs 0, state IDLE, no `srr*_wr` ever pulses.
- `msr_rd`=32'h0000_9001, `npc`=32'h0000_1234, `pipe_empty`=1, raise `ext_irq` → SAVE writes SRR0=32'h0000_1234 and SRR1=32'h0000_9001. VECTOR writes MSR=32'h0000_1001 and redirects to 32'h0000_0500; `int_ack` pulses once; redirect lands `SYNC_STAGES`+3 cycles after `ext_irq`.
- `ext_irq` high with `msr_ee`=0 for 20 cycles → no strobes and `stall_req`=0.
- `pipe_empty` held low 5 cycles in DRAIN → `stall_req` high throughout, SAVE only after `pipe_empty` rises. Separately, drop `ext_irq` in DRAIN → return to IDLE with no writes.
- `rfi_req` with `srr0_rd`=32'h0000_2007, `srr1_rd`=32'hFFFF_FFFF → `msr_wd`=32'h0000_9001, `redirect_pc`=32'h0000_2004.
- `rfi_req` and `irq_s`&`msr_ee` in the same IDLE cycle → RFI first. Then, with restored EE=1 and `ext_irq` still high, DRAIN follows immediately.
